// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch path.
//   fetchState_t : fetch FSM states (REQ issues a read, WAIT expects the
//                  response, DROP swallows a response made stale by a redirect)
//   NOP_INSTR    : instruction presented when the queue is empty
//   PC_STEP      : byte distance between consecutive instruction words
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetchState_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Storage for prefetched instructions: DEPTH entries of {instruction, PCPlus4}.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   push, pushInstr,
//   pushPCPlus4           : append an entry at the tail
//   pop                   : remove the head entry
//   flush                 : empty the queue; wins over push and pop
//   headValid, headInstr,
//   headPCPlus4           : head entry, zeros when the queue is empty
//   count                 : number of occupied entries
// The caller guarantees push only when not full and pop only when not empty.
module fetch_queue_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [31:0]              pushInstr,
    input  logic [31:0]              pushPCPlus4,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     headValid,
    output logic [31:0]              headInstr,
    output logic [31:0]              headPCPlus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      entries_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic [63:0]      headEntry_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents of free slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries_r[wrPtr_r] <= {pushInstr, pushPCPlus4};
        end
    end

    // Head presentation: stale storage is masked to NOP / zero when empty.
    always_comb begin
        headEntry_s = entries_r[rdPtr_r];
        headValid   = (count_r != {CNT_W{1'b0}});
        if (headValid) begin
            headInstr   = headEntry_s[63:32];
            headPCPlus4 = headEntry_s[31:0];
        end else begin
            headInstr   = NOP_INSTR;
            headPCPlus4 = 32'h0000_0000;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID register.
// Owns the fetch PC, issues one word read at a time over a ready/valid
// handshake and buffers returned words with their PC+4.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   redirect, redirectPC          : taken branch from ID; flush and refetch
//   hold                          : IF/ID stall; blocks draining only
//   memReq, memAddr, memReady     : request channel (one outstanding read)
//   memValid, memData             : response channel
//   instrValid, instruction,
//   PCPlus4, count                : queue head and occupancy
module instr_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirectPC,
    input  logic                     hold,
    output logic                     memReq,
    output logic [31:0]              memAddr,
    input  logic                     memReady,
    input  logic                     memValid,
    input  logic [31:0]              memData,
    output logic                     instrValid,
    output logic [31:0]              instruction,
    output logic [31:0]              PCPlus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetchState_t state_r;
    fetchState_t nextState_s;
    logic [31:0] fetchPC_r;
    logic [31:0] nextFetchPC_s;
    logic [31:0] tagPC_r;
    logic [31:0] nextTagPC_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    // Request and queue-control decode. memReq looks only at registered state
    // (plus reset, so nothing is requested while the block is held in reset).
    always_comb begin
        memReq = 1'b0;
        if (reset) begin
            memReq = 1'b0;
        end else if ((state_r == REQ) && (count < FULL_COUNT)) begin
            memReq = 1'b1;
        end else begin
            memReq = 1'b0;
        end
        accept_s = memReq & memReady;
        // A response is only written when we are waiting for a live request;
        // a redirect in the same cycle makes it stale.
        push_s   = (state_r == WAIT) & memValid & ~redirect;
        pop_s    = instrValid & ~hold & ~redirect;
    end

    // Next-state logic; redirect turns an outstanding or just-accepted read
    // into one whose response must be swallowed.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            REQ: begin
                if (accept_s) begin
                    if (redirect) begin
                        nextState_s = DROP;
                    end else begin
                        nextState_s = WAIT;
                    end
                end else begin
                    nextState_s = REQ;
                end
            end
            WAIT: begin
                if (memValid) begin
                    nextState_s = REQ;
                end else if (redirect) begin
                    nextState_s = DROP;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DROP: begin
                if (memValid) begin
                    nextState_s = REQ;
                end else begin
                    nextState_s = DROP;
                end
            end
            default: nextState_s = REQ;
        endcase
    end

    // Fetch PC and response tag; redirect overrides the sequential increment.
    always_comb begin
        nextFetchPC_s = fetchPC_r;
        nextTagPC_s   = tagPC_r;
        if (redirect) begin
            nextFetchPC_s = redirectPC;
        end else if (accept_s) begin
            nextFetchPC_s = fetchPC_r + PC_STEP;
        end else begin
            nextFetchPC_s = fetchPC_r;
        end
        if (accept_s) begin
            nextTagPC_s = fetchPC_r;
        end else begin
            nextTagPC_s = tagPC_r;
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= REQ;
            fetchPC_r <= RESET_PC;
            tagPC_r   <= 32'h0000_0000;
        end else begin
            state_r   <= nextState_s;
            fetchPC_r <= nextFetchPC_s;
            tagPC_r   <= nextTagPC_s;
        end
    end

    assign memAddr = fetchPC_r;

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push_s),
        .pushInstr   (memData),
        .pushPCPlus4 (tagPC_r + PC_STEP),
        .pop         (pop_s),
        .flush       (redirect),
        .headValid   (instrValid),
        .headInstr   (instruction),
        .headPCPlus4 (PCPlus4),
        .count       (count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a transaction-level model
// (queue of {instr, PC+4}, fetch PC, one pending-read flag with a stale mark)
// is compared against the DUT every cycle, with directed scenarios followed
// by randomized traffic from a variable-latency memory.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect;
    logic [31:0]   redirectPC;
    logic          hold;
    logic          memReq;
    logic [31:0]   memAddr;
    logic          memReady;
    logic          memValid;
    logic [31:0]   memData;
    logic          instrValid;
    logic [31:0]   instruction;
    logic [31:0]   PCPlus4;
    logic [CW-1:0] count;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirectPC(redirectPC),
        .hold(hold), .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
        .memValid(memValid), .memData(memData), .instrValid(instrValid),
        .instruction(instruction), .PCPlus4(PCPlus4), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] mFetchPC;
    logic [31:0] mTag;
    bit          mPending;
    bit          mStale;
    // Memory responder state
    bit          rspBusy;
    int          rspDelay;
    logic [31:0] rspAddr;
    int          fixedDelay;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mFetchPC = RESET_PC;
        mTag     = 32'h0;
        mPending = 1'b0;
        mStale   = 1'b0;
    endtask

    task automatic compareAll();
        bit expReq;
        expReq = !reset && !mPending && (mq.size() < DEPTH);
        chk("memReq", {31'd0, memReq}, {31'd0, expReq});
        chk("memAddr", memAddr, mFetchPC);
        chk("count", {{(32-CW){1'b0}}, count}, mq.size());
        chk("instrValid", {31'd0, instrValid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("instruction", instruction, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
        chk("PCPlus4", PCPlus4, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_memReq"}, {31'd0, memReq}, 32'd0);
        chk({tag, "_memAddr"}, memAddr, RESET_PC);
        chk({tag, "_count"}, {{(32-CW){1'b0}}, count}, 32'd0);
        chk({tag, "_instrValid"}, {31'd0, instrValid}, 32'd0);
        chk({tag, "_instruction"}, instruction, 32'h0);
        chk({tag, "_PCPlus4"}, PCPlus4, 32'h0);
    endtask

    // One clock cycle: compare at negedge, drive inputs, advance model, posedge.
    task automatic step(input bit rdir, input logic [31:0] rpc, input bit hld, input bit rdy);
        bit          expReq;
        bit          accept;
        bit          respond;
        bit          doPush;
        bit          doPop;
        logic [31:0] oldPC;
        @(negedge clk);
        compareAll();
        redirect   = rdir;
        redirectPC = rpc;
        hold       = hld;
        memReady   = rdy;
        memValid   = rspBusy && (rspDelay == 0);
        memData    = memValid ? memWord(rspAddr) : $urandom;

        expReq  = !mPending && (mq.size() < DEPTH);
        accept  = expReq && rdy;
        respond = memValid && mPending;
        doPush  = respond && !mStale && !rdir;
        doPop   = (mq.size() != 0) && !hld && !rdir;
        oldPC   = mFetchPC;
        if (rdir) begin
            mq.delete();
            if (accept) begin
                mPending = 1'b1;
                mStale   = 1'b1;
            end else if (respond) begin
                mPending = 1'b0;
            end else if (mPending) begin
                mStale = 1'b1;
            end
            mFetchPC = rpc;
        end else begin
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back({memData, mTag + 32'd4});
            if (respond) mPending = 1'b0;
            if (accept) begin
                mPending = 1'b1;
                mStale   = 1'b0;
                mTag     = mFetchPC;
                mFetchPC = mFetchPC + 32'd4;
            end
        end

        if (memValid) rspBusy = 1'b0;
        else if (rspBusy) rspDelay--;
        if (accept) begin
            rspBusy  = 1'b1;
            rspDelay = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
            rspAddr  = oldPC;
        end
        @(posedge clk);
    endtask

    // Let any outstanding read complete without issuing a new one.
    task automatic drainPending();
        int n = 0;
        while (mPending && n < 20) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        chk("drainPending_timeout", {31'd0, mPending}, 32'd0);
    endtask

    task automatic midReset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkResetValues("asyncReset");
        modelReset();
        redirect = 1'b0; hold = 1'b0; memReady = 1'b0; memValid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // The memory still delivers the read that was in flight before reset.
        rspBusy  = 1'b1;
        rspDelay = 1;
    endtask

    initial begin
        int n;
        bit r;
        logic [31:0] rpc;
        reset = 1'b1; redirect = 1'b0; redirectPC = 32'h0; hold = 1'b0;
        memReady = 1'b0; memValid = 1'b0; memData = 32'h0;
        rspBusy = 1'b0; rspDelay = 0; rspAddr = 32'h0; fixedDelay = 0;
        modelReset();
        #12;
        checkResetValues("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Zero-wait memory: first word appears after accept + response.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("first_instrValid", {31'd0, instrValid}, 32'd1);
        chk("first_instruction", instruction, 32'hDEAD_0000);
        chk("first_PCPlus4", PCPlus4, 32'd4);
        chk("first_next_memAddr", memAddr, 32'd4);
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Hold: queue fills to DEPTH and requests stop.
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("hold_count_full", {{(32-CW){1'b0}}, count}, 32'd4);
        chk("hold_memReq_off", {31'd0, memReq}, 32'd0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("hold_drained", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("hold_memReq_resumed", {31'd0, memReq}, 32'd1);

        // Redirect while waiting; response arrives one cycle later and is dropped.
        drainPending();
        fixedDelay = 1;
        n = 0;
        while (!mPending && n < 20) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk("wait_entry_timeout", {31'd0, mPending}, 32'd1);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("redir_count", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("redir_memAddr", memAddr, 32'h40);
        chk("redir_memReq", {31'd0, memReq}, 32'd1);
        fixedDelay = 0;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("redir_head_instr", instruction, 32'hDEAD_0040);
        chk("redir_head_PCPlus4", PCPlus4, 32'h44);

        // Redirect in the same cycle the request is accepted.
        drainPending();
        step(1'b1, 32'h100, 1'b0, 1'b1);
        #1;
        chk("stale_memReq_off", {31'd0, memReq}, 32'd0);
        chk("stale_memAddr", memAddr, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("stale_dropped_count", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("stale_memReq_back", {31'd0, memReq}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("stale_target_PCPlus4", PCPlus4, 32'h104);

        // Address wrap at the top of the address space.
        drainPending();
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("wrap_memAddr", memAddr, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("wrap_PCPlus4", PCPlus4, 32'h0);
        chk("wrap_instruction", instruction, 32'h2152_FFFC);

        // Reset while a read is outstanding; late response must be ignored.
        drainPending();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        midReset();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("late_valid_ignored", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("late_valid_memReq", {31'd0, memReq}, 32'd1);

        // Randomized traffic.
        fixedDelay = -1;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 7))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF8;
                default: rpc = $urandom & 32'h0000_FFFC;
            endcase
            step(r, rpc, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60));
        end
        @(negedge clk);
        compareAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
